// File: rtl/dbg_bus_bridge.sv
// Debug bus master: parses command frames from the UART rx byte stream, issues one
// femto bus access per frame, and returns read data plus a status byte on tx.
module dbg_bus_bridge #(
  parameter int XLEN      = 32,
  parameter int BUS_WIDTH = 32,
  parameter int ACC_W     = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_vld,
  output logic [7:0]           tx_data,
  output logic                 tx_vld,
  input  logic                 tx_rdy,
  input  logic                 bus_gnt,
  output logic [XLEN-1:0]      bus_addr,
  output logic                 bus_w_rb,
  output logic [ACC_W-1:0]     bus_acc,
  output logic [BUS_WIDTH-1:0] bus_wdata,
  output logic                 bus_req,
  input  logic [BUS_WIDTH-1:0] bus_rdata,
  input  logic                 bus_resp,
  output logic                 busy
);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_REQ, S_WAIT, S_TXDATA, S_TXSTAT
  } state_t;

  state_t                 state, state_nx;
  logic                   w_rb;
  logic [1:0]             acc;
  logic [1:0]             cnt;
  logic [1:0]             last_idx;
  logic [1:0]             cnt_inc;
  logic [TW-1:0]          tmo;
  logic                   overrun;
  logic                   ovr_nx;
  logic                   drop;
  logic                   tx_hs;
  logic                   tmo_hit;
  logic [XLEN-1:0]        addr;
  logic [BUS_WIDTH-1:0]   wdata;
  logic [BUS_WIDTH-1:0]   rdata;

  function automatic logic [7:0] stat_byte(input logic ovr, input logic [1:0] code);
    return {ovr, 5'b0, code};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    tx_hs    = tx_vld && tx_rdy;
    last_idx = (acc == 2'd0) ? 2'd0 : (acc == 2'd1) ? 2'd1 : 2'd3;
    cnt_inc  = cnt + 2'd1;
    // abort fires so that the status byte appears exactly TIMEOUT cycles after bus_req
    tmo_hit  = (tmo == TW'(TIMEOUT - 2));
    drop     = rx_vld && (state inside {S_REQ, S_WAIT, S_TXDATA, S_TXSTAT});
    ovr_nx   = overrun || drop;
    state_nx = state;
    bus_req  = 1'b0;
    case (state)
      S_IDLE:   if (rx_vld) state_nx = (rx_data[1:0] == 2'd3) ? S_TXSTAT : S_ADDR;
      S_ADDR:   if (rx_vld && cnt == 2'd3) state_nx = w_rb ? S_WDATA : S_REQ;
      S_WDATA:  if (rx_vld && cnt == last_idx) state_nx = S_REQ;
      S_REQ: begin
        if (bus_gnt) begin
          bus_req  = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_resp)     state_nx = w_rb ? S_TXSTAT : S_TXDATA;
        else if (tmo_hit) state_nx = S_TXSTAT;
      end
      S_TXDATA: if (tx_hs && cnt == last_idx) state_nx = S_TXSTAT;
      S_TXSTAT: if (tx_hs) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_rb    <= 1'b0;
      acc     <= 2'd0;
      cnt     <= 2'd0;
      tmo     <= '0;
      overrun <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      rdata   <= '0;
      tx_vld  <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      // a drop in the same cycle as the status handshake is a fresh, unreported overrun
      overrun <= (state == S_TXSTAT && tx_hs) ? drop : ovr_nx;
      case (state)
        S_IDLE: begin
          if (rx_vld) begin
            w_rb  <= rx_data[7];
            acc   <= rx_data[1:0];
            cnt   <= 2'd0;
            wdata <= '0;
            if (rx_data[1:0] == 2'd3) begin
              tx_vld  <= 1'b1;
              tx_data <= stat_byte(ovr_nx, 2'd1);
            end
          end
        end
        S_ADDR: begin
          if (rx_vld) begin
            addr[{cnt, 3'b000} +: 8] <= rx_data;
            cnt                      <= cnt_inc;
          end
        end
        S_WDATA: begin
          if (rx_vld) begin
            wdata[{cnt, 3'b000} +: 8] <= rx_data;
            cnt                       <= cnt_inc;
          end
        end
        S_REQ:  tmo <= '0;
        S_WAIT: begin
          tmo <= tmo + 1'b1;
          if (bus_resp) begin
            rdata   <= bus_rdata;
            cnt     <= 2'd0;
            tx_vld  <= 1'b1;
            tx_data <= w_rb ? stat_byte(ovr_nx, 2'd0) : bus_rdata[7:0];
          end else if (tmo_hit) begin
            tx_vld  <= 1'b1;
            tx_data <= stat_byte(ovr_nx, 2'd2);
          end
        end
        S_TXDATA: begin
          if (tx_hs) begin
            if (cnt == last_idx) begin
              tx_data <= stat_byte(ovr_nx, 2'd0);
            end else begin
              cnt     <= cnt_inc;
              tx_data <= rdata[{cnt_inc, 3'b000} +: 8];
            end
          end
        end
        S_TXSTAT: if (tx_hs) tx_vld <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus_addr  = addr;
  assign bus_w_rb  = w_rb;
  assign bus_acc   = ACC_W'(acc);
  assign bus_wdata = wdata;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_dbg_bus_bridge.sv
// Scoreboard bench for dbg_bus_bridge: frame-level reference model feeds expected
// bus requests and tx bytes to queues; a negedge monitor pops and compares.
module tb_dbg_bus_bridge;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic        bus_gnt;
  logic [31:0] bus_addr;
  logic        bus_w_rb;
  logic [1:0]  bus_acc;
  logic [31:0] bus_wdata;
  logic        bus_req;
  logic [31:0] bus_rdata;
  logic        bus_resp;
  logic        busy;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [1:0]  acc;
    logic [31:0] wd;
  } req_t;

  req_t       exp_req[$];
  logic [7:0] exp_tx[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int t_last = 0;
  int hold_until = 0;

  dbg_bus_bridge #(.XLEN(32), .BUS_WIDTH(32), .ACC_W(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .bus_gnt(bus_gnt),
    .bus_addr(bus_addr), .bus_w_rb(bus_w_rb), .bus_acc(bus_acc),
    .bus_wdata(bus_wdata), .bus_req(bus_req), .bus_rdata(bus_rdata),
    .bus_resp(bus_resp), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: event not expected or not seen (cycle %0d)", nm, cyc);
  endtask

  // transmitter: random backpressure, forced low while cyc < hold_until
  initial begin
    tx_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1 tx_rdy = (cyc < hold_until) ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // monitor: pops expectations whenever the DUT presents a tx byte or a bus request
  initial begin
    logic       pv = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] pd = 8'h00;
    req_t       r;
    forever begin
      @(negedge clk);
      if (stall) begin
        chk("tx_hold_vld", tx_vld, 1);
        chk("tx_hold_dat", tx_data, pd);
      end
      if (tx_vld && !pv) rise_cyc = cyc;
      if (tx_vld && tx_rdy) begin
        if (exp_tx.size() == 0) flag("tx_extra_byte");
        else chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (bus_req) begin
        chk("req_gnt", bus_gnt, 1);
        if (exp_req.size() == 0) flag("req_extra");
        else begin
          r = exp_req.pop_front();
          chk("req_addr", bus_addr, r.a);
          chk("req_w_rb", bus_w_rb, r.w);
          chk("req_acc", bus_acc, r.acc);
          if (r.w) chk("req_wdata", bus_wdata, r.wd);
        end
      end
      stall = tx_vld && !tx_rdy && !rst;
      pd    = tx_data;
      pv    = tx_vld;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1 rx_vld = 1'b0;
    end
    @(posedge clk);
    #1 rx_vld = 1'b1;
    rx_data = b;
    t_last  = cyc;
  endtask

  task automatic wait_req(output int c);
    c = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus_req) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) flag("req_timeout");
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) flag("idle_timeout");
  endtask

  // d = slave response delay in cycles after bus_req (0 = never, late resp at +20)
  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int g, input int d, input bit inj, input int hold);
    int nb, c, k_end;
    logic [1:0]  ac;
    logic [31:0] m;
    ac = cmd[1:0];
    if (ac == 2'd3) begin
      exp_tx.push_back(8'h01);
      send_byte(cmd);
      @(posedge clk);
      #1 rx_vld = 1'b0;
      wait_idle();
      chk("illegal_tx_rise", rise_cyc, t_last + 1);
      return;
    end
    nb = 1 << ac;
    m  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    exp_req.push_back('{a, cmd[7], ac, wd & m});
    if (!cmd[7] && d > 0)
      for (int i = 0; i < nb; i++) exp_tx.push_back(8'((rd >> (8 * i)) & 32'hFF));
    exp_tx.push_back({inj, 5'b0, (d > 0) ? 2'b00 : 2'b10});

    bus_gnt = (g == 0);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(8'((a >> (8 * i)) & 32'hFF));
    if (cmd[7]) for (int i = 0; i < nb; i++) send_byte(8'((wd >> (8 * i)) & 32'hFF));
    @(posedge clk);
    #1 rx_vld = 1'b0;
    if (g > 0) begin
      repeat (g) @(posedge clk);
      #1 bus_gnt = 1'b1;
    end
    wait_req(c);
    chk("req_latency", c, t_last + 1 + g);
    if (hold > 0) hold_until = c + ((d > 0) ? d + 1 : TMO) + hold;

    k_end = (d > 0) ? d : 20;
    for (int k = 1; k <= k_end; k++) begin
      @(posedge clk);
      #1 rx_vld = inj && (k == 1);
      rx_data   = 8'($urandom);
      bus_resp  = (k == k_end);
      bus_rdata = (k == k_end) ? rd : $urandom;
    end
    @(posedge clk);
    #1 rx_vld = 1'b0;
    bus_resp = 1'b0;
    wait_idle();
    chk("tx_rise_delay", rise_cyc - c, (d > 0) ? d + 1 : TMO);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_vld"}, tx_vld, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_bus_req"}, bus_req, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_w_rb"}, bus_w_rb, 0);
    chk({tag, "_bus_acc"}, bus_acc, 0);
    chk({tag, "_bus_wdata"}, bus_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d, pick;
    logic [7:0] cmd;
    rst = 1'b1; rx_vld = 1'b0; rx_data = 8'h00; bus_gnt = 1'b1;
    bus_rdata = 32'h0; bus_resp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst_init");
    @(posedge clk);
    #1 rst = 1'b0;

    run_frame(8'h02, 32'h2000_0000, 32'h0, 32'hDEAD_BEEF, 0, 3, 1'b0, 0);
    run_frame(8'h80, 32'h3000_0010, 32'h5A5A_5AA5, 32'h0, 5, 2, 1'b0, 0);
    run_frame(8'h02, 32'h1234_5678, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0, 0);
    run_frame(8'h03, 32'h0, 32'h0, 32'h0, 0, 1, 1'b0, 0);
    run_frame(8'h01, 32'h0000_0100, 32'h0, 32'hAAAA_1357, 0, TMO - 1, 1'b0, 0);
    run_frame(8'h81, 32'h4000_0004, 32'h7777_BEEF, 32'h0, 0, 3, 1'b1, 10);
    run_frame(8'h02, 32'h4000_0008, 32'h0, 32'h0102_0304, 0, 2, 1'b0, 0);
    run_frame(8'h02, 32'h5000_0000, 32'h0, 32'h89AB_CDEF, 2, 4, 1'b1, 10);

    // reset after two address bytes
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    @(posedge clk);
    #1 rx_vld = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_addr");
    run_frame(8'h82, 32'h6000_0020, 32'h1122_3344, 32'h0, 0, 1, 1'b0, 0);

    // reset while the access is outstanding; the late resp must be ignored
    exp_req.push_back('{32'h7000_0000, 1'b0, 2'd2, 32'h0});
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte((i == 3) ? 8'h70 : 8'h00);
    @(posedge clk);
    #1 rx_vld = 1'b0;
    wait_req(c);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus_resp = 1'b1;
    bus_rdata = 32'hFEED_FACE;
    @(posedge clk);
    #1 bus_resp = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_tx_vld", tx_vld, 0);
    chk("post_rst_busy", busy, 0);

    for (int n = 0; n < 40; n++) begin
      cmd  = 8'($urandom);
      pick = $urandom_range(0, 9);
      d    = (pick == 0) ? 0 : (pick == 1) ? TMO - 1 : $urandom_range(1, TMO - 2);
      run_frame(cmd, $urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
                d, ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0) ? 8 : 0);
    end

    repeat (5) @(negedge clk);
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("req_queue_drained", exp_req.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbg_bus_bridge.md
Name: dbg_bus_bridge

Overview:
Byte-stream debug master for the femto system bus; it sits upstream of the address decoder as a second bus master, muxed with the core through an external grant. It parses command frames from a UART receive byte stream, issues single bus reads/writes using the standard req/resp protocol, and returns read data and a status byte on a transmit byte stream. A cycle timeout recovers from slaves that never respond, including faulted accesses whose resp is suppressed.

Parameters:
XLEN, 32, bus address width
BUS_WIDTH, 32, bus data width
ACC_W, 2, bus_acc width; 0=byte, 1=half, 2=word, 3=illegal
TIMEOUT, 1024, max cycles from req to resp before abort (≥2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte
rx_vld  in  1  one-cycle pulse, rx_data valid
tx_data  out  8  byte to transmit
tx_vld  out  1  tx_data valid, held until tx_rdy
tx_rdy  in  1  transmitter accepts byte when tx_vld&tx_rdy
bus_gnt  in  1  bridge owns bus this cycle
bus_addr  out  XLEN  access address
bus_w_rb  out  1  1=write, 0=read
bus_acc  out  ACC_W  access size
bus_wdata  out  BUS_WIDTH  write data, LSB-aligned
bus_req  out  1  one-cycle request pulse
bus_rdata  in  BUS_WIDTH  read data, valid with bus_resp
bus_resp  in  1  one-cycle completion pulse
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; tx_vld=0, tx_data=0, bus_req=0, bus_addr=0, bus_w_rb=0, bus_acc=0, bus_wdata=0, busy=0, overrun flag=0, all counters 0.
- Frame: CMD byte (bit7=w_rb, bits1:0=acc, bits6:2 ignored), then 4 address bytes LSB first, then for writes N=1/2/4 data bytes LSB first (N from acc).
- IDLE: on rx_vld, latch w_rb/acc. acc==3 -> TXSTAT with code 0x01; no bus access and no further bytes consumed. Otherwise -> ADDR with byte count 0.
- ADDR: each rx_vld shifts a byte into addr[8*k+:8]. After the 4th byte, go to WDATA if write, else REQ.
- WDATA: collect N bytes into wdata[8*k+:8]; upper unused bytes are zero. After the Nth byte -> REQ.
- REQ: wait for bus_gnt. In the cycle bus_gnt=1, drive bus_req=1 for exactly that cycle, clear the timeout counter, -> WAIT. Addr/w_rb/acc/wdata stay stable from REQ until leaving WAIT.
- WAIT: count cycles. On bus_resp, capture bus_rdata; a read goes to TXDATA (N bytes), a write goes to TXSTAT code 0x00. If the counter reaches TIMEOUT without resp -> TXSTAT code 0x02; any later stray bus_resp is ignored.
- TXDATA: present rdata bytes LSB first (byte k = rdata[8*k+:8]), one per tx handshake. After N handshakes -> TXSTAT code 0x00.
- TXSTAT: tx_data = {overrun, 5'b0, code[1:0]}. On handshake, clear overrun -> IDLE.
- tx_vld/tx_data are registered. Once tx_vld is raised, tx_data is stable until the handshake. tx_vld=1 and tx_rdy=1 in the same cycle completes the byte. The next byte may be presented the following cycle.
- rx_vld while in REQ/WAIT/TXDATA/TXSTAT: byte dropped, overrun set (sticky).
- Read latency: command end to bus_req = 1 cycle + grant wait. Timeout abort fires at exactly TIMEOUT cycles after bus_req.
- rst mid-frame or mid-access: immediate return to reset state; an outstanding bus_resp after reset is ignored.

Test Plan:
- Word read: rx 0x02,0x00,0x00,0x00,0x20; gnt=1; slave resp after 3 cycles with rdata 0xDEADBEEF -> single bus_req with addr 0x20000000, w_rb=0, acc=2; tx 0xEF,0xBE,0xAD,0xDE,0x00.
- Byte write with grant delay: rx 0x80,0x10,0x00,0x00,0x30,0xA5; gnt held low 5 cycles -> bus_req only in the first gnt=1 cycle; addr 0x30000010, wdata 0x000000A5, acc=0; resp -> tx 0x00.
- Timeout: word read, no resp, TIMEOUT=16 -> tx 0x02 exactly 16 cycles after bus_req; a late resp at cycle 20 produces no extra tx byte.
- Illegal acc: rx 0x03 -> no bus_req; tx 0x01; next frame parses normally.
- Overrun plus tx backpressure: inject rx byte during WAIT; hold tx_rdy low 10 cycles -> tx_data stable throughout; status byte 0x80; next status 0x00.
- Reset in ADDR after 2 address bytes -> all outputs at reset values; a new full frame works.
